// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode: FIFO of {inst, pc} pairs with flush.
// Define FETCHQ_BYPASS_EN to let an empty queue pass the incoming word straight to decode.
module fetch_queue #(
   parameter int IW    = 9,
   parameter int PW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [IW-1:0]              in_inst,
   input  logic [PW-1:0]              in_pc,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [IW-1:0]              out_inst,
   output logic [PW-1:0]              out_pc,
   input  logic                       out_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [IW+PW-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             stored_valid;
   logic             bypass;
   logic             push;
   logic             pop;
   logic [IW+PW-1:0] head;

   assign stored_valid = (cnt_q != '0);
   // in_ready depends on registered occupancy only, never on out_ready
   assign in_ready     = (cnt_q < CW'(DEPTH));

`ifdef FETCHQ_BYPASS_EN
   assign bypass = !stored_valid && in_valid && !flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word consumed by decode in the same cycle is never stored
   assign push = in_valid && in_ready && !flush && !(bypass && out_ready);
   assign pop  = stored_valid && out_ready && !flush;

   always_comb begin
      head      = '0;
      out_valid = stored_valid || bypass;
      if (bypass)
         head = {in_inst, in_pc};
      else if (stored_valid)
         head = mem[rd_ptr];
   end

   assign out_inst = head[IW+PW-1:PW];
   assign out_pc   = head[PW-1:0];
   assign count    = cnt_q;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {in_inst, in_pc};
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter IW, default 9: instruction width in bits, matching the InstROM word.
REQ-002 Parameter PW, default 8: PC width in bits.
REQ-003 Parameter DEPTH, default 4: queue entries, a power of two and at least 2.
REQ-004 clk  input  1: single clock; all state changes on the rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  1: the fetch stage presents an instruction.
REQ-007 in_inst  input  IW: instruction word from InstROM.
REQ-008 in_pc  input  PW: PC of in_inst.
REQ-009 in_ready  output  1: the queue accepts a push this cycle.
REQ-010 out_valid  output  1: the head entry is presented to decode.
REQ-011 out_inst  output  IW: head instruction.
REQ-012 out_pc  output  PW: head PC.
REQ-013 out_ready  input  1: decode consumes the head this cycle.
REQ-014 flush  input  1: branch taken; discard all queued entries.
REQ-015 count  output  $clog2(DEPTH+1): current occupancy.

Function
REQ-016 A push SHALL occur on a rising edge when in_valid && in_ready && !flush, and SHALL write {in_inst, in_pc} at the write pointer.
REQ-017 A pop SHALL occur on a rising edge when out_valid && out_ready && !flush, and SHALL advance the read pointer.
REQ-018 in_ready SHALL equal (count < DEPTH), SHALL be registered-state-derived only, and SHALL have no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0), except where REQ-032 applies.
REQ-020 out_inst and out_pc SHALL present the entry at the read pointer and SHALL be all-zero whenever out_valid is 0.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 count SHALL increment on push-only, decrement on pop-only, and remain unchanged on a simultaneous push and pop.
REQ-023 When full, in_valid SHALL be ignored and no entry SHALL be overwritten, even if a pop occurs in the same cycle.
REQ-024 When empty, out_ready SHALL have no effect.
REQ-025 flush SHALL take priority over push and pop in the same cycle.
REQ-026 On the edge with flush=1, the pointers and count SHALL clear to 0; out_valid SHALL be 0 from the following cycle.
REQ-027 An in_valid arriving in the same cycle as flush SHALL be dropped.
REQ-028 Entries SHALL leave the queue in push order, and each SHALL keep its own PC pairing.

Reset
REQ-029 While reset=0, read and write pointers and count SHALL be 0; out_valid SHALL be 0, out_inst and out_pc SHALL be 0, and in_ready SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-031 Storage contents need not be reset; REQ-020 masks them at the outputs.

Configuration
REQ-032 With FETCHQ_BYPASS_EN defined, when count==0 and in_valid=1, the queue SHALL present:
- out_valid=1, out_inst=in_inst and out_pc=in_pc combinationally in the same cycle;
- if out_ready=1, the word SHALL be consumed without being stored and count SHALL stay 0;
- bypass SHALL be suppressed while flush=1.
REQ-033 Without FETCHQ_BYPASS_EN, a pushed entry SHALL first appear on out_valid one cycle after the push edge; minimum latency is 1 cycle.

Verification
REQ-034 Reset release; push 0x1A5@pc 0x00, 0x0F3@pc 0x01 with out_ready=0 -> count=2; out_inst=0x1A5, out_pc=0x00.
REQ-035 Push 4 entries with out_ready=0, then hold in_valid with 0x111 -> in_ready=0, count=4, and 0x111 never appears at the output.
REQ-036 At count=2, push and pop in the same cycle -> count stays 2; the head advances to the 2nd entry.
REQ-037 At count=3, assert flush with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, and the flushed-cycle word is absent.
REQ-038 Push 10 entries interleaved with pops, crossing the pointer wrap -> the output sequence equals the input sequence exactly, with PCs matched.
REQ-039 Drive reset=0 asynchronously mid-cycle at count=3 -> count=0 and out_valid=0 before the next edge. With FETCHQ_BYPASS_EN and the queue empty, in_valid plus out_ready -> same-cycle out_valid=1 and count stays 0.
